gp9001_host_if: RTL
===================

// Module: gp9001_host_if
// PURPOSE
//  GP9001 VDP host-side bus interface. Consumes the level op strobes driven by the 68k CPU block and returns
//  GP9001ACK. Owns the VRAM word pointer, register-select latch and control register file. Drives the CPU-side
//  port of the external dual-port VRAM; the renderer reads VRAM and REG_FLAT on its own side.
// PARAMETERS
//  VRAM_AW   13  VRAM word-address width; pointer wraps modulo 2**VRAM_AW
//  REG_AW    4   register-index width; 2**REG_AW 16-bit control registers
// PORTS
//  CLK96            in   1            system clock; all logic on rising edge
//  RESET96_N        in   1            synchronous, active-low reset
//  OP_SELECT_REG    in   1            level op request: latch register index from DIN[REG_AW-1:0]
//  OP_WRITE_REG     in   1            level op request: write DIN to selected register
//  OP_WRITE_RAM     in   1            level op request: write DIN to VRAM[ptr], then ptr+1
//  OP_READ_RAM_H    in   1            level op request: read VRAM[ptr], ptr unchanged
//  OP_READ_RAM_L    in   1            level op request: read VRAM[ptr], then ptr+1
//  OP_SET_RAM_PTR   in   1            level op request: ptr <= DIN[VRAM_AW-1:0]
//  DIN              in   16           CPU write data, stable while any op is high
//  DOUT             out  16           read data; valid while ACK=1 after a read op
//  ACK              out  1            four-phase handshake acknowledge (feeds the CPU block's GP9001ACK)
//  VRAM_ADDR        out  VRAM_AW      CPU-side VRAM word address
//  VRAM_DIN         out  16           VRAM write data
//  VRAM_WE          out  1            VRAM write enable, word-wide, one-cycle pulse
//  VRAM_Q           in   16           VRAM read data, 1-cycle latency after VRAM_ADDR
//  REG_FLAT         out  16*2**REG_AW register file, reg n at [16n+15:16n]
//  REG_IDX          out  REG_AW       currently selected register index
// BEHAVIOUR
//  Reset (RESET96_N=0 at clock edge, takes priority in any state):
//   - FSM=IDLE; ACK=0; DOUT=0; ptr=0; REG_IDX=0; REG_FLAT=0; VRAM_WE=0.
//   - Mid-operation reset aborts the op with no VRAM write.
//  FSM:
//   - IDLE:  no strobe high -> stay. Any strobe -> latch op code and DIN -> EXEC.
//            Simultaneous strobes resolve by fixed priority SET_RAM_PTR > SELECT_REG > WRITE_REG > WRITE_RAM
//            > READ_RAM_L > READ_RAM_H. Only the winner executes.
//   - EXEC:
//       SET_RAM_PTR, SELECT_REG, WRITE_REG: update state this cycle -> DONE.
//       WRITE_RAM: VRAM_WE=1 for this cycle only, VRAM_ADDR=ptr, VRAM_DIN=latched DIN; ptr+1 -> DONE.
//       READ_*: VRAM_ADDR=ptr -> RDWAIT.
//   - RDWAIT: DOUT<=VRAM_Q; READ_RAM_L does ptr+1 -> DONE.
//   - DONE:  ACK=1 and DOUT held. All strobes low -> IDLE with ACK=0 on the next cycle.
//            If strobes are already low on DONE entry (early withdrawal), ACK stays high one cycle, then IDLE.
//  Latency, strobe rise to ACK high:
//   - 2 cycles for register/pointer/write ops.
//   - 3 cycles for read ops.
//  Handshake rules:
//   - ACK never rises in IDLE, EXEC or RDWAIT.
//   - A new op is never accepted until ACK has returned low.
//   - An op whose strobes fall before DONE still completes.
//  Pointer: increment wraps (2**VRAM_AW-1)+1 -> 0. SET_RAM_PTR ignores DIN bits above VRAM_AW.
//  Registers: WRITE_REG targets REG_IDX as latched by the last SELECT_REG. DIN bits above REG_AW are ignored on select.
//  VRAM_ADDR tracks ptr outside EXEC; VRAM_WE is 0 in every state except the EXEC cycle of WRITE_RAM.
// STRUCTURE
//  Shared package gp9001_pkg:
//   - op code enum (OP_NONE, OP_SETPTR, OP_SELREG, OP_WREG, OP_WRAM, OP_RDL, OP_RDH)
//   - FSM state enum (IDLE, EXEC, RDWAIT, DONE)
//   - priority-encode function
//  Sub-module gp9001_regfile: REG_AW-indexed write port, flat read-out, synchronous clear.
//  FSM, pointer and VRAM port logic stay in gp9001_host_if.
// TESTING
//  1. SET_RAM_PTR DIN=0x1234 (VRAM_AW=13) -> ptr=0x1234&0x1FFF=0x1234; ACK high 2 cycles after strobe.
//     Drop strobe -> ACK low next cycle.
//  2. ptr=0x1FFF; WRITE_RAM DIN=0xBEEF -> single VRAM_WE pulse at addr 0x1FFF with data 0xBEEF; ptr wraps to 0x0000.
//  3. ptr=0x0010 with VRAM[0x10]=0xA5A5 -> READ_RAM_H: DOUT=0xA5A5, ptr stays 0x10.
//     Then READ_RAM_L: DOUT=0xA5A5, ptr=0x11; ACK 3 cycles after strobe.
//  4. SELECT_REG DIN=0x00F3, then WRITE_REG DIN=0x0140 -> REG_IDX=3, REG_FLAT[63:48]=0x0140, other registers 0.
//  5. SET_RAM_PTR and WRITE_RAM asserted together DIN=0x0020 -> only ptr=0x0020, no VRAM_WE.
//     Strobe dropped one cycle after rise -> op completes; ACK pulses exactly one cycle.
//  6. Assert RESET96_N=0 during RDWAIT -> next cycle ACK=0, DOUT=0, ptr=0, REG_FLAT=0, FSM IDLE, no VRAM_WE.

Source files
------------

// File: rtl/gp9001_pkg.sv
// gp9001_pkg: types and helpers shared by the GP9001 host interface.
//   op_t       - decoded host operation latched on acceptance
//   state_t    - handshake FSM states
//   prio_op()  - resolves simultaneous strobes to a single winning op
package gp9001_pkg;

  typedef enum logic [2:0] {
    OP_NONE   = 3'd0,
    OP_SETPTR = 3'd1,
    OP_SELREG = 3'd2,
    OP_WREG   = 3'd3,
    OP_WRAM   = 3'd4,
    OP_RDL    = 3'd5,
    OP_RDH    = 3'd6
  } op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    RDWAIT = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Fixed priority: SET_RAM_PTR > SELECT_REG > WRITE_REG > WRITE_RAM > READ_RAM_L > READ_RAM_H
  function automatic op_t prio_op(input logic setptr, input logic selreg, input logic wreg,
                                  input logic wram, input logic rdl, input logic rdh);
    op_t op;
    op = OP_NONE;
    if (setptr)      op = OP_SETPTR;
    else if (selreg) op = OP_SELREG;
    else if (wreg)   op = OP_WREG;
    else if (wram)   op = OP_WRAM;
    else if (rdl)    op = OP_RDL;
    else if (rdh)    op = OP_RDH;
    return op;
  endfunction

endpackage

// File: rtl/gp9001_regfile.sv
// gp9001_regfile: 2**REG_AW x 16-bit control register file.
//   CLK96      in   clock
//   RESET96_N  in   synchronous active-low clear of every register
//   WE         in   write strobe
//   WIDX       in   register index to write
//   WDATA      in   write data
//   REG_FLAT   out  all registers, reg n at [16n+15:16n]
module gp9001_regfile #(
  parameter int REG_AW = 4
) (
  input  logic                       CLK96,
  input  logic                       RESET96_N,
  input  logic                       WE,
  input  logic [REG_AW-1:0]          WIDX,
  input  logic [15:0]                WDATA,
  output logic [16*(2**REG_AW)-1:0]  REG_FLAT
);
  import gp9001_pkg::*;

  localparam int NREG = 2**REG_AW;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      logic [15:0] reg_val_reg;

      always_ff @(posedge CLK96) begin
        if (!RESET96_N)
          reg_val_reg <= 16'h0000;
        else if (WE && (WIDX == REG_AW'(gi)))
          reg_val_reg <= WDATA;
      end

      assign REG_FLAT[16*gi +: 16] = reg_val_reg;
    end
  endgenerate

endmodule

// File: rtl/gp9001_host_if.sv
// gp9001_host_if: GP9001 VDP host-side bus interface.
// Accepts level op strobes from the CPU block, executes one op at a time and
// acknowledges with a four-phase ACK. Owns the VRAM word pointer, the
// register-select latch and the control register file.
//   CLK96, RESET96_N          clock, synchronous active-low reset
//   OP_*                      level op requests (see gp9001_pkg::prio_op)
//   DIN / DOUT / ACK          CPU data in, read data out, acknowledge
//   VRAM_ADDR/DIN/WE, VRAM_Q  CPU-side port of the external dual-port VRAM
//   REG_FLAT, REG_IDX         register file contents, selected register
module gp9001_host_if #(
  parameter int VRAM_AW = 13,
  parameter int REG_AW  = 4
) (
  input  logic                       CLK96,
  input  logic                       RESET96_N,
  input  logic                       OP_SELECT_REG,
  input  logic                       OP_WRITE_REG,
  input  logic                       OP_WRITE_RAM,
  input  logic                       OP_READ_RAM_H,
  input  logic                       OP_READ_RAM_L,
  input  logic                       OP_SET_RAM_PTR,
  input  logic [15:0]                DIN,
  output logic [15:0]                DOUT,
  output logic                       ACK,
  output logic [VRAM_AW-1:0]         VRAM_ADDR,
  output logic [15:0]                VRAM_DIN,
  output logic                       VRAM_WE,
  input  logic [15:0]                VRAM_Q,
  output logic [16*(2**REG_AW)-1:0]  REG_FLAT,
  output logic [REG_AW-1:0]          REG_IDX
);
  import gp9001_pkg::*;

  state_t              state_reg;
  op_t                 op_reg;
  logic [15:0]         din_reg;
  logic [15:0]         dout_reg;
  logic                ack_reg;
  logic                vram_we_reg;
  logic [VRAM_AW-1:0]  ptr_reg;
  logic [REG_AW-1:0]   reg_idx_reg;
  op_t                 win_op;
  logic                any_strobe;
  logic                reg_we;

  assign win_op = prio_op(OP_SET_RAM_PTR, OP_SELECT_REG, OP_WRITE_REG,
                          OP_WRITE_RAM, OP_READ_RAM_L, OP_READ_RAM_H);
  assign any_strobe = (win_op != OP_NONE);

  always_ff @(posedge CLK96) begin
    if (!RESET96_N) begin
      state_reg   <= IDLE;
      op_reg      <= OP_NONE;
      din_reg     <= 16'h0000;
      dout_reg    <= 16'h0000;
      ack_reg     <= 1'b0;
      vram_we_reg <= 1'b0;
      ptr_reg     <= '0;
      reg_idx_reg <= '0;
    end else begin
      // Write enable is raised only for the single EXEC cycle of WRITE_RAM.
      vram_we_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (any_strobe) begin
            op_reg      <= win_op;
            din_reg     <= DIN;
            vram_we_reg <= (win_op == OP_WRAM);
            state_reg   <= EXEC;
          end
        end
        EXEC: begin
          case (op_reg)
            OP_SETPTR: begin
              ptr_reg   <= din_reg[VRAM_AW-1:0];
              ack_reg   <= 1'b1;
              state_reg <= DONE;
            end
            OP_SELREG: begin
              reg_idx_reg <= din_reg[REG_AW-1:0];
              ack_reg     <= 1'b1;
              state_reg   <= DONE;
            end
            OP_WREG: begin
              ack_reg   <= 1'b1;
              state_reg <= DONE;
            end
            OP_WRAM: begin
              ptr_reg   <= ptr_reg + VRAM_AW'(1);
              ack_reg   <= 1'b1;
              state_reg <= DONE;
            end
            OP_RDL, OP_RDH: state_reg <= RDWAIT;
            default:        state_reg <= IDLE;
          endcase
        end
        RDWAIT: begin
          // VRAM_Q now reflects the address presented during EXEC.
          dout_reg <= VRAM_Q;
          if (op_reg == OP_RDL)
            ptr_reg <= ptr_reg + VRAM_AW'(1);
          ack_reg   <= 1'b1;
          state_reg <= DONE;
        end
        DONE: begin
          if (!any_strobe) begin
            ack_reg   <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // The register write lands on the EXEC edge, together with ACK rising.
  assign reg_we = (state_reg == EXEC) && (op_reg == OP_WREG);

  gp9001_regfile #(.REG_AW(REG_AW)) u_regfile (
    .CLK96     (CLK96),
    .RESET96_N (RESET96_N),
    .WE        (reg_we),
    .WIDX      (reg_idx_reg),
    .WDATA     (din_reg),
    .REG_FLAT  (REG_FLAT)
  );

  assign DOUT      = dout_reg;
  assign ACK       = ack_reg;
  assign VRAM_ADDR = ptr_reg;
  assign VRAM_DIN  = din_reg;
  assign VRAM_WE   = vram_we_reg;
  assign REG_IDX   = reg_idx_reg;

endmodule
